// File: rtl/alu_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_entry
// Purpose  : Front end for the 8-bit ALU demo. Operand A, operand B and a
//            3-bit opcode are entered one after another from one 8-switch
//            bank, stepped by two debounced pushbuttons. The captured fields
//            are held in registers for the ALU.
// Ports    : clk        system clock
//            rst_n      asynchronous active-low reset
//            sw[7:0]    raw switches (A/B data, sw[2:0] opcode)
//            btn_next   raw button: capture current field and advance
//            btn_back   raw button: step back without capturing
//            op_a/op_b  registered operands
//            alu_sel    registered opcode
//            ops_valid  one-cycle pulse after a full operand set is committed
//            state_code 00 ENTER_A, 01 ENTER_B, 10 ENTER_OP, 11 SHOW
// Options  : define ALU_OPERAND_ENTRY_TIMEOUT_EN to abort an entry left idle
//            in ENTER_B/ENTER_OP for TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn_next,
    input  logic       btn_back,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [2:0] alu_sel,
    output logic       ops_valid,
    output logic [1:0] state_code
);

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'b00,
        ST_ENTER_B  = 2'b01,
        ST_ENTER_OP = 2'b10,
        ST_SHOW     = 2'b11
    } state_t;

    state_t     r_state;
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;     // [0] next pulse, [1] back pulse
    logic       w_next;
    logic       w_back;
    logic       w_timeout;

    assign w_btn_raw = {btn_back, btn_next};

    // ------------------------------------------------------------------
    // Per-button synchronizer + debouncer + rising-edge detector
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_deb;
            logic             r_deb_q;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    r_deb_q <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        // Level has differed for DEBOUNCE_CYCLES edges: accept it
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_deb & ~r_deb_q;
        end
    endgenerate

    assign w_next = w_press[0];
    assign w_back = w_press[1];

    // ------------------------------------------------------------------
    // Idle timeout for abandoned entries
    // ------------------------------------------------------------------
`ifdef ALU_OPERAND_ENTRY_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_in_entry;

    assign w_in_entry = (r_state == ST_ENTER_B) || (r_state == ST_ENTER_OP);
    assign w_timeout  = w_in_entry && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Any press pulse restarts the count; every state change other than the
    // timeout itself comes from a press, and the timeout clears it too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_next || w_back || !w_in_entry || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    // Entry states wait indefinitely; the parameter only keeps the
    // interface identical between builds.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ------------------------------------------------------------------
    // Entry FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ENTER_A;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            alu_sel   <= 3'b000;
            ops_valid <= 1'b0;
        end else begin
            ops_valid <= 1'b0;
            if (w_next && !w_back) begin
                case (r_state)
                    ST_ENTER_A: begin
                        op_a    <= sw;
                        r_state <= ST_ENTER_B;
                    end
                    ST_ENTER_B: begin
                        op_b    <= sw;
                        r_state <= ST_ENTER_OP;
                    end
                    ST_ENTER_OP: begin
                        // Opcode and valid land together so the ALU sees the
                        // complete set in the cycle ops_valid is high.
                        alu_sel   <= sw[2:0];
                        ops_valid <= 1'b1;
                        r_state   <= ST_SHOW;
                    end
                    default: r_state <= ST_ENTER_A;
                endcase
            end else if (w_back && !w_next) begin
                case (r_state)
                    ST_ENTER_B:  r_state <= ST_ENTER_A;
                    ST_ENTER_OP: r_state <= ST_ENTER_B;
                    ST_SHOW:     r_state <= ST_ENTER_OP;
                    default:     r_state <= ST_ENTER_A;
                endcase
            end else if (!w_next && !w_back && w_timeout) begin
                r_state <= ST_ENTER_A;
            end
        end
    end

    assign state_code = r_state;

endmodule
`default_nettype wire

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Input-side front end for the 8-bit ALU demo; the input counterpart to the 7-segment/LED output path.
- Lets the user enter operand A, operand B and the 3-bit opcode one after another from a single 8-switch bank, stepped by two pushbuttons.
- Debounces the buttons and holds registered operands and opcode for the ALU.
- Drives a state code so the LEDs/display can show which field is being entered.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- TIMEOUT_CYCLES, 500000000: idle cycles before an abandoned entry is aborted (used only with ENTRY_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  8  raw switch bank (data for A, B; sw[2:0] for opcode)
- btn_next  input  1  raw pushbutton: capture field / advance
- btn_back  input  1  raw pushbutton: step back without capture
- op_a  output  8  registered operand A
- op_b  output  8  registered operand B
- alu_sel  output  3  registered opcode
- ops_valid  output  1  one-cycle pulse when a full operand set has been committed
- state_code  output  2  current state: 00 ENTER_A, 01 ENTER_B, 10 ENTER_OP, 11 SHOW

Behaviour:
- Reset (async assert, sync release via clk):
  - op_a = 0, op_b = 0, alu_sel = 0, ops_valid = 0.
  - State ENTER_A (state_code = 00).
  - Debounced levels = 0, counters = 0.
- Each button passes through its own 2-FF synchronizer, then a debouncer:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press pulse = debounced & ~debounced_q, one cycle wide.
- Latency: a raw press held stable is acted on by the FSM at the (DEBOUNCE_CYCLES+3)th rising clk edge after it goes high. Release generates no action.
- FSM on next_pulse only:
  - ENTER_A: op_a <= sw; go to ENTER_B.
  - ENTER_B: op_b <= sw; go to ENTER_OP.
  - ENTER_OP: alu_sel <= sw[2:0]; go to SHOW; ops_valid = 1 for the following single cycle.
  - SHOW: go to ENTER_A. Registers are held; the previous result stays displayed until the next commit.
- FSM on back_pulse only:
  - ENTER_B -> ENTER_A; ENTER_OP -> ENTER_B; SHOW -> ENTER_OP.
  - ENTER_A stays in ENTER_A.
  - No register is modified.
- next_pulse and back_pulse in the same cycle: both ignored, no state or register change.
- op_a, op_b and alu_sel change only on their capture edge. They never track sw live.
- The ALU sees new operands the same cycle ops_valid goes high.
- ops_valid is never asserted for two consecutive cycles.
- Reset asserted mid-entry: everything returns to reset values immediately; partially entered fields are discarded.

Optional Feature:
- Macro: ALU_OPERAND_ENTRY_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_CYCLES idle counter runs while in ENTER_B or ENTER_OP.
  - It clears on any press pulse and on state change.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to ENTER_A. op_b and alu_sel are unchanged; no ops_valid pulse.
  - If the timeout and a press pulse fall in the same cycle, the press wins.
- Not defined: no counter; entry states wait indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=20.
- Full entry: sw=0x3C + next, sw=0x05 + next, sw=0x01 + next -> op_a=0x3C, op_b=0x05, alu_sel=3'b001; ops_valid high for exactly 1 cycle; state_code=11; action on edge 7 after each press.
- Bounce: btn_next toggles high for 2 cycles, low 1, high 2, then low -> no state change and no register change.
- Back: in ENTER_OP press back -> state_code=01, op_a/op_b unchanged; press back twice more -> ENTER_A both times; press next with sw=0xAA -> op_a=0xAA.
- Simultaneous: btn_next and btn_back rise on the same cycle in ENTER_B -> state stays 01, op_b unchanged.
- Reset mid-entry: after capturing A=0xFF, assert rst_n=0 for one partial cycle -> op_a=0 immediately, state_code=00, ops_valid=0.
- Timeout (macro defined): enter ENTER_B, then idle 20 cycles -> state_code=00, no ops_valid. Macro undefined: same stimulus -> state_code stays 01.
